// File: rtl/gip_boot_rom_arbiter_pkg.sv
// Shared definitions for the boot ROM arbiter: per-port response state encoding,
// port identifiers and the burst counter helper.
package gip_boot_rom_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HELD    = 2'd2
  } port_state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int BURST_W = 4;

  function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
    return (v == {BURST_W{1'b1}}) ? v : v + BURST_W'(1);
  endfunction

endpackage

// File: rtl/gip_boot_rom_resp_port.sv
// One requester's response side: tracks the outstanding ROM read, captures data
// into a hold register when the consumer stalls, and reports grant eligibility.
module gip_boot_rom_resp_port
  import gip_boot_rom_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_grant,
  input  logic                  i_resp_ready,
  input  logic [DATA_WIDTH-1:0] i_rom_read_data,
  output logic                  o_eligible,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output port_state_t           o_state
);

  port_state_t           r_state;
  port_state_t           w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hold;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ROM output only lives for one cycle, so a stalled PENDING response is latched here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold <= '0;
    end else if (r_state == ST_PENDING && !i_resp_ready) begin
      r_hold <= i_rom_read_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_grant) begin
      w_state_nxt = ST_PENDING;
    end else begin
      case (r_state)
        ST_PENDING: w_state_nxt = i_resp_ready ? ST_IDLE : ST_HELD;
        ST_HELD:    w_state_nxt = i_resp_ready ? ST_IDLE : ST_HELD;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign o_resp_valid = (r_state == ST_PENDING) || (r_state == ST_HELD);
  assign o_resp_data  = (r_state == ST_HELD) ? r_hold : i_rom_read_data;
  assign o_eligible   = i_req && !(o_resp_valid && !i_resp_ready);
  assign o_state      = r_state;

endmodule

// File: rtl/gip_boot_rom_arbiter.sv
// Arbitrates the single-ported synchronous boot ROM between instruction fetch (F)
// and data load (D), returning one-cycle-latency read data per port.
module gip_boot_rom_arbiter
  import gip_boot_rom_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int PRIORITY_FIXED  = 0,
  parameter int FETCH_BURST_MAX = 4
) (
  input  logic                  rom_clock,
  input  logic                  rom_reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  fetch_ack,
  output logic                  fetch_resp_valid,
  input  logic                  fetch_resp_ready,
  output logic [DATA_WIDTH-1:0] fetch_resp_data,
  input  logic                  data_req,
  input  logic [ADDR_WIDTH-1:0] data_address,
  output logic                  data_ack,
  output logic                  data_resp_valid,
  input  logic                  data_resp_ready,
  output logic [DATA_WIDTH-1:0] data_resp_data,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_read,
  input  logic [DATA_WIDTH-1:0] rom_read_data,
  output port_state_t           o_fetch_state,
  output port_state_t           o_data_state
);

  localparam logic [BURST_W-1:0] LP_BURST_MAX = BURST_W'(FETCH_BURST_MAX);

  logic                  w_f_elig;
  logic                  w_d_elig;
  logic                  w_grant_f;
  logic                  w_grant_d;
  logic                  w_burst_block;
  logic                  r_last_grant;
  logic [BURST_W-1:0]    r_burst_count;
  logic [ADDR_WIDTH-1:0] r_last_address;

  // Handshakes: a request transfers when req && ack in the same cycle (ack is the
  // combinational grant); a response transfers when resp_valid && resp_ready.
  always_comb begin
    w_grant_f     = 1'b0;
    w_grant_d     = 1'b0;
    w_burst_block = (LP_BURST_MAX != '0) && (r_burst_count == LP_BURST_MAX) && w_d_elig;
    if (PRIORITY_FIXED != 0) begin
      if (w_f_elig && !w_burst_block) begin
        w_grant_f = 1'b1;
      end else if (w_d_elig) begin
        w_grant_d = 1'b1;
      end
    end else if (w_f_elig && w_d_elig) begin
      w_grant_f = (r_last_grant == PORT_D);
      w_grant_d = (r_last_grant == PORT_F);
    end else begin
      w_grant_f = w_f_elig;
      w_grant_d = w_d_elig;
    end
    if (rom_reset) begin
      w_grant_f = 1'b0;
      w_grant_d = 1'b0;
    end
  end

  assign fetch_ack   = w_grant_f;
  assign data_ack    = w_grant_d;
  assign rom_read    = w_grant_f || w_grant_d;
  assign rom_address = w_grant_f ? fetch_address :
                       w_grant_d ? data_address  : r_last_address;

  always_ff @(posedge rom_clock or posedge rom_reset) begin
    if (rom_reset) begin
      r_last_grant   <= PORT_D;
      r_last_address <= '0;
      r_burst_count  <= '0;
    end else begin
      if (w_grant_f) begin
        r_last_grant   <= PORT_F;
        r_last_address <= fetch_address;
      end else if (w_grant_d) begin
        r_last_grant   <= PORT_D;
        r_last_address <= data_address;
      end
      // Counts fetch grants only while D is actually being held off.
      if (w_grant_d || !w_d_elig) begin
        r_burst_count <= '0;
      end else if (w_grant_f) begin
        r_burst_count <= sat_inc(r_burst_count);
      end
    end
  end

  gip_boot_rom_resp_port #(.DATA_WIDTH(DATA_WIDTH)) u_fetch_port (
    .i_clk           (rom_clock),
    .i_rst           (rom_reset),
    .i_req           (fetch_req),
    .i_grant         (w_grant_f),
    .i_resp_ready    (fetch_resp_ready),
    .i_rom_read_data (rom_read_data),
    .o_eligible      (w_f_elig),
    .o_resp_valid    (fetch_resp_valid),
    .o_resp_data     (fetch_resp_data),
    .o_state         (o_fetch_state)
  );

  gip_boot_rom_resp_port #(.DATA_WIDTH(DATA_WIDTH)) u_data_port (
    .i_clk           (rom_clock),
    .i_rst           (rom_reset),
    .i_req           (data_req),
    .i_grant         (w_grant_d),
    .i_resp_ready    (data_resp_ready),
    .i_rom_read_data (rom_read_data),
    .o_eligible      (w_d_elig),
    .o_resp_valid    (data_resp_valid),
    .o_resp_data     (data_resp_data),
    .o_state         (o_data_state)
  );

endmodule

// File: tb/tb_gip_boot_rom_arbiter.sv
// Directed bench for the boot ROM arbiter: round-robin instance plus two fixed-priority
// instances (burst limit 4 and unlimited), each with a one-cycle ROM model.
module tb_gip_boot_rom_arbiter;
  import gip_boot_rom_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return 32'hB007_0000 ^ {20'h0, a};
  endfunction

  // Round-robin instance signals
  logic        rr_f_req, rr_f_rdy, rr_f_ack, rr_f_vld;
  logic [11:0] rr_f_addr;
  logic [31:0] rr_f_data;
  logic        rr_d_req, rr_d_rdy, rr_d_ack, rr_d_vld;
  logic [11:0] rr_d_addr;
  logic [31:0] rr_d_data;
  logic [11:0] rr_rom_addr;
  logic        rr_rom_rd;
  logic [31:0] rr_rom_q = '0;
  port_state_t rr_f_st, rr_d_st;

  // Fixed priority, burst limit 4
  logic        x4_f_req, x4_f_ack, x4_f_vld, x4_d_req, x4_d_ack, x4_d_vld, x4_rom_rd;
  logic [31:0] x4_f_data, x4_d_data;
  logic [11:0] x4_rom_addr;
  logic [31:0] x4_rom_q = '0;
  port_state_t x4_f_st, x4_d_st;

  // Fixed priority, unlimited burst
  logic        x0_f_req, x0_f_ack, x0_f_vld, x0_d_req, x0_d_ack, x0_d_vld, x0_rom_rd;
  logic [31:0] x0_f_data, x0_d_data;
  logic [11:0] x0_rom_addr;
  logic [31:0] x0_rom_q = '0;
  port_state_t x0_f_st, x0_d_st;

  always @(posedge clk) if (rr_rom_rd) rr_rom_q <= rom_word(rr_rom_addr);
  always @(posedge clk) if (x4_rom_rd) x4_rom_q <= rom_word(x4_rom_addr);
  always @(posedge clk) if (x0_rom_rd) x0_rom_q <= rom_word(x0_rom_addr);

  gip_boot_rom_arbiter #(.PRIORITY_FIXED(0)) u_rr (
    .rom_clock(clk), .rom_reset(rst),
    .fetch_req(rr_f_req), .fetch_address(rr_f_addr), .fetch_ack(rr_f_ack),
    .fetch_resp_valid(rr_f_vld), .fetch_resp_ready(rr_f_rdy), .fetch_resp_data(rr_f_data),
    .data_req(rr_d_req), .data_address(rr_d_addr), .data_ack(rr_d_ack),
    .data_resp_valid(rr_d_vld), .data_resp_ready(rr_d_rdy), .data_resp_data(rr_d_data),
    .rom_address(rr_rom_addr), .rom_read(rr_rom_rd), .rom_read_data(rr_rom_q),
    .o_fetch_state(rr_f_st), .o_data_state(rr_d_st)
  );

  gip_boot_rom_arbiter #(.PRIORITY_FIXED(1), .FETCH_BURST_MAX(4)) u_x4 (
    .rom_clock(clk), .rom_reset(rst),
    .fetch_req(x4_f_req), .fetch_address(12'h0F0), .fetch_ack(x4_f_ack),
    .fetch_resp_valid(x4_f_vld), .fetch_resp_ready(1'b1), .fetch_resp_data(x4_f_data),
    .data_req(x4_d_req), .data_address(12'h07D), .data_ack(x4_d_ack),
    .data_resp_valid(x4_d_vld), .data_resp_ready(1'b1), .data_resp_data(x4_d_data),
    .rom_address(x4_rom_addr), .rom_read(x4_rom_rd), .rom_read_data(x4_rom_q),
    .o_fetch_state(x4_f_st), .o_data_state(x4_d_st)
  );

  gip_boot_rom_arbiter #(.PRIORITY_FIXED(1), .FETCH_BURST_MAX(0)) u_x0 (
    .rom_clock(clk), .rom_reset(rst),
    .fetch_req(x0_f_req), .fetch_address(12'h0F0), .fetch_ack(x0_f_ack),
    .fetch_resp_valid(x0_f_vld), .fetch_resp_ready(1'b1), .fetch_resp_data(x0_f_data),
    .data_req(x0_d_req), .data_address(12'h07D), .data_ack(x0_d_ack),
    .data_resp_valid(x0_d_vld), .data_resp_ready(1'b1), .data_resp_data(x0_d_data),
    .rom_address(x0_rom_addr), .rom_read(x0_rom_rd), .rom_read_data(x0_rom_q),
    .o_fetch_state(x0_f_st), .o_data_state(x0_d_st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_rr(input logic fr, input logic [11:0] fa, input logic fy,
                          input logic dr, input logic [11:0] da, input logic dy);
    rr_f_req = fr; rr_f_addr = fa; rr_f_rdy = fy;
    rr_d_req = dr; rr_d_addr = da; rr_d_rdy = dy;
  endtask

  initial begin
    rst = 1'b1;
    x4_f_req = 1'b0; x4_d_req = 1'b0; x0_f_req = 1'b0; x0_d_req = 1'b0;
    drive_rr(1'b1, 12'h001, 1'b1, 1'b1, 12'h002, 1'b1);

    // Reset: requests present but nothing granted
    settle();
    chk("rst_acks", 32'({rr_f_ack, rr_d_ack}), 32'h0);
    chk("rst_rom_read", 32'(rr_rom_rd), 32'h0);
    chk("rst_f_valid", 32'(rr_f_vld), 32'h0);
    chk("rst_d_valid", 32'(rr_d_vld), 32'h0);

    tick(); rst = 1'b0; drive_rr(1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1);
    settle();
    chk("idle_rom_addr", 32'(rr_rom_addr), 32'h0);
    chk("idle_rom_read", 32'(rr_rom_rd), 32'h0);

    // Round-robin alternation, F wins the first tie
    tick(); drive_rr(1'b1, 12'h020, 1'b1, 1'b1, 12'h040, 1'b1); settle();
    chk("rr0_acks", 32'({rr_f_ack, rr_d_ack}), 32'h2);
    chk("rr0_addr", 32'(rr_rom_addr), 32'h020);
    tick(); drive_rr(1'b1, 12'h021, 1'b1, 1'b1, 12'h040, 1'b1); settle();
    chk("rr1_acks", 32'({rr_f_ack, rr_d_ack}), 32'h1);
    chk("rr1_addr", 32'(rr_rom_addr), 32'h040);
    chk("rr1_f_valid", 32'(rr_f_vld), 32'h1);
    chk("rr1_f_data", rr_f_data, 32'hB007_0020);
    chk("rr1_d_valid", 32'(rr_d_vld), 32'h0);
    tick(); drive_rr(1'b1, 12'h021, 1'b1, 1'b1, 12'h041, 1'b1); settle();
    chk("rr2_acks", 32'({rr_f_ack, rr_d_ack}), 32'h2);
    chk("rr2_addr", 32'(rr_rom_addr), 32'h021);
    chk("rr2_d_data", rr_d_data, 32'hB007_0040);
    chk("rr2_f_valid", 32'(rr_f_vld), 32'h0);
    tick(); drive_rr(1'b1, 12'h022, 1'b1, 1'b1, 12'h041, 1'b1); settle();
    chk("rr3_acks", 32'({rr_f_ack, rr_d_ack}), 32'h1);
    chk("rr3_addr", 32'(rr_rom_addr), 32'h041);
    chk("rr3_f_data", rr_f_data, 32'hB007_0021);
    tick(); drive_rr(1'b1, 12'h022, 1'b1, 1'b0, 12'h000, 1'b1); settle();
    chk("rr4_acks", 32'({rr_f_ack, rr_d_ack}), 32'h2);
    chk("rr4_d_data", rr_d_data, 32'hB007_0041);
    tick(); drive_rr(1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1); settle();
    chk("rr5_rom_read", 32'(rr_rom_rd), 32'h0);
    chk("rr5_last_addr", 32'(rr_rom_addr), 32'h022);
    chk("rr5_f_data", rr_f_data, 32'hB007_0022);

    // Single F stream, back-to-back with no bubbles
    for (int i = 0; i < 3; i++) begin
      tick(); drive_rr(1'b1, 12'(i), 1'b1, 1'b0, 12'h000, 1'b1); settle();
      chk("fs_ack", 32'(rr_f_ack), 32'h1);
      chk("fs_addr", 32'(rr_rom_addr), 32'(i));
      chk("fs_valid", 32'(rr_f_vld), (i == 0) ? 32'h0 : 32'h1);
      if (i > 0) chk("fs_data", rr_f_data, 32'hB007_0000 + 32'(i - 1));
    end
    tick(); drive_rr(1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1); settle();
    chk("fs3_ack", 32'(rr_f_ack), 32'h0);
    chk("fs3_valid", 32'(rr_f_vld), 32'h1);
    chk("fs3_data", rr_f_data, 32'hB007_0002);
    chk("fs3_last_addr", 32'(rr_rom_addr), 32'h002);

    // F stall at 0x10 while D is served
    tick(); drive_rr(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 1'b1); settle();
    chk("st0_f_valid", 32'(rr_f_vld), 32'h0);
    chk("st0_f_ack", 32'(rr_f_ack), 32'h1);
    tick(); drive_rr(1'b1, 12'h011, 1'b0, 1'b1, 12'h050, 1'b1); settle();
    chk("st1_acks", 32'({rr_f_ack, rr_d_ack}), 32'h1);
    chk("st1_f_data", rr_f_data, 32'hB007_0010);
    chk("st1_f_state", 32'(rr_f_st), 32'(ST_PENDING));
    tick(); drive_rr(1'b1, 12'h011, 1'b0, 1'b1, 12'h051, 1'b1); settle();
    chk("st2_acks", 32'({rr_f_ack, rr_d_ack}), 32'h1);
    chk("st2_f_state", 32'(rr_f_st), 32'(ST_HELD));
    chk("st2_f_data", rr_f_data, 32'hB007_0010);
    chk("st2_d_data", rr_d_data, 32'hB007_0050);
    tick(); drive_rr(1'b1, 12'h011, 1'b0, 1'b0, 12'h000, 1'b1); settle();
    chk("st3_acks", 32'({rr_f_ack, rr_d_ack}), 32'h0);
    chk("st3_f_data", rr_f_data, 32'hB007_0010);
    chk("st3_last_addr", 32'(rr_rom_addr), 32'h051);
    chk("st3_d_data", rr_d_data, 32'hB007_0051);
    tick(); drive_rr(1'b1, 12'h011, 1'b1, 1'b0, 12'h000, 1'b1); settle();
    chk("st4_f_ack", 32'(rr_f_ack), 32'h1);
    chk("st4_addr", 32'(rr_rom_addr), 32'h011);
    chk("st4_f_data", rr_f_data, 32'hB007_0010);
    chk("st4_d_valid", 32'(rr_d_vld), 32'h0);
    tick(); drive_rr(1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1); settle();
    chk("st5_f_state", 32'(rr_f_st), 32'(ST_PENDING));
    chk("st5_f_data", rr_f_data, 32'hB007_0011);
    tick(); settle();
    chk("st6_f_valid", 32'(rr_f_vld), 32'h0);

    // Reset asserted while F is PENDING
    tick(); drive_rr(1'b1, 12'h030, 1'b1, 1'b0, 12'h000, 1'b1); settle();
    chk("rp0_f_ack", 32'(rr_f_ack), 32'h1);
    tick(); drive_rr(1'b1, 12'h031, 1'b1, 1'b0, 12'h000, 1'b1);
    #1;
    chk("rp1_pre_valid", 32'(rr_f_vld), 32'h1);
    chk("rp1_pre_ack", 32'(rr_f_ack), 32'h1);
    rst = 1'b1;
    #1;
    chk("rp1_valid", 32'(rr_f_vld), 32'h0);
    chk("rp1_ack", 32'(rr_f_ack), 32'h0);
    chk("rp1_rom_read", 32'(rr_rom_rd), 32'h0);
    chk("rp1_state", 32'(rr_f_st), 32'(ST_IDLE));
    tick(); rst = 1'b0; drive_rr(1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1); settle();
    chk("rp2_last_addr", 32'(rr_rom_addr), 32'h0);
    tick(); drive_rr(1'b1, 12'h060, 1'b1, 1'b1, 12'h061, 1'b1); settle();
    chk("rp3_acks", 32'({rr_f_ack, rr_d_ack}), 32'h2);
    chk("rp3_addr", 32'(rr_rom_addr), 32'h060);
    tick(); drive_rr(1'b0, 12'h000, 1'b1, 1'b1, 12'h061, 1'b1); settle();
    chk("rp4_acks", 32'({rr_f_ack, rr_d_ack}), 32'h1);
    chk("rp4_f_data", rr_f_data, 32'hB007_0060);
    tick(); drive_rr(1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1); settle();
    chk("rp5_d_data", rr_d_data, 32'hB007_0061);

    // Fixed priority: limit 4 gives F,F,F,F,D; unlimited never grants D
    tick();
    x4_f_req = 1'b1; x4_d_req = 1'b1; x0_f_req = 1'b1; x0_d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("fx4_acks", 32'({x4_f_ack, x4_d_ack}), ((i % 5) == 4) ? 32'h1 : 32'h2);
      chk("fx0_acks", 32'({x0_f_ack, x0_d_ack}), 32'h2);
      if (i == 5) chk("fx4_d_data", x4_d_data, 32'hB007_007D);
      if (i == 5) chk("fx4_d_valid", 32'(x4_d_vld), 32'h1);
      if (i == 3) chk("fx4_f_data", x4_f_data, 32'hB007_00F0);
      tick();
    end
    settle();
    chk("fx0_d_valid", 32'(x0_d_vld), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
